minhash_signature_gen: RTL and testbench

Streaming MinHash front end that sits directly upstream of `sorter`. It consumes one document at a time as a stream of 32-bit shingle elements, hashes each element with a fixed multiply-xor hash, and keeps the running minimum. At the end of each document it emits a single-cycle `valid_out` with the minimum hash (`signature_out`) and the document index (`index_out`). These connect directly to the sorter's `valid_in`, `signature_in` and `index_in`.

---
 rtl/minhash_pkg.sv | 18 +
 rtl/minhash_hash_stage.sv | 52 +++++
 rtl/minhash_signature_gen.sv | 143 ++++++++++++++
 tb/tb_minhash_signature_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/minhash_pkg.sv
// Shared constants and types for the MinHash signature front end.
// Optional feature macro: MINHASH_ELEM_COUNT_EN (per-document element count).
package minhash_pkg;

  localparam int SIGNATURE_WIDTH  = 32;
  localparam int INDEX_WIDTH      = 10;
  localparam int ELEMENT_WIDTH    = 32;
  localparam int ELEM_COUNT_WIDTH = 16;

  localparam logic [31:0] HASH_MULT = 32'h9E3779B1;
  localparam logic [31:0] HASH_XOR  = 32'h00000000;

  typedef enum logic {
    IDLE,
    ACCUM
  } minhash_state_t;

endpackage

// File: rtl/minhash_hash_stage.sv
// Multiply-xor hash lane plus its S1 pipeline register.
// Carries document framing (first/last) and the sampled index alongside.
module minhash_hash_stage
  import minhash_pkg::*;
#(
  parameter int          SW   = SIGNATURE_WIDTH,
  parameter int          EW   = ELEMENT_WIDTH,
  parameter int          IW   = INDEX_WIDTH,
  parameter logic [31:0] MULT = HASH_MULT,
  parameter logic [31:0] XMSK = HASH_XOR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          elem_valid,
  input  logic [EW-1:0] elem_data,
  input  logic          elem_last,
  input  logic          elem_first,
  input  logic [IW-1:0] elem_index,
  output logic          s1_valid,
  output logic [SW-1:0] s1_hash,
  output logic          s1_last,
  output logic          s1_first,
  output logic [IW-1:0] s1_index
);

  logic [SW-1:0] prod;
  logic [SW-1:0] hash;

  // Only the low product bits are kept.
  assign prod = SW'(elem_data) * SW'(MULT);
  assign hash = prod ^ SW'(XMSK);

  // S1 register; a cleared valid drops in-flight work on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hash  <= '0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_index <= '0;
    end else begin
      s1_valid <= elem_valid;
      if (elem_valid) begin
        s1_hash  <= hash;
        s1_last  <= elem_last;
        s1_first <= elem_first;
        s1_index <= elem_index;
      end
    end
  end

endmodule

// File: rtl/minhash_signature_gen.sv
// Streaming MinHash: hash each shingle, keep the per-document minimum.
// Optional macro MINHASH_ELEM_COUNT_EN adds elem_count_out.
module minhash_signature_gen
  import minhash_pkg::*;
#(
  parameter int          SIGNATURE_WIDTH = minhash_pkg::SIGNATURE_WIDTH,
  parameter int          INDEX_WIDTH     = minhash_pkg::INDEX_WIDTH,
  parameter int          ELEMENT_WIDTH   = minhash_pkg::ELEMENT_WIDTH,
  parameter logic [31:0] HASH_MULT       = minhash_pkg::HASH_MULT,
  parameter logic [31:0] HASH_XOR        = minhash_pkg::HASH_XOR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       elem_valid,
  input  logic [ELEMENT_WIDTH-1:0]   elem_data,
  input  logic                       elem_last,
  input  logic [INDEX_WIDTH-1:0]     doc_index,
  output logic                       valid_out,
  output logic [SIGNATURE_WIDTH-1:0] signature_out,
  output logic [INDEX_WIDTH-1:0]     index_out,
  output logic                       busy
`ifdef MINHASH_ELEM_COUNT_EN
  ,
  output logic [ELEM_COUNT_WIDTH-1:0] elem_count_out
`endif
);

  localparam int SW = SIGNATURE_WIDTH;
  localparam int IW = INDEX_WIDTH;

  minhash_state_t state;
  logic [IW-1:0]  idx_cap;
  logic           s0_first;
  logic [IW-1:0]  s0_index;

  logic           s1_valid;
  logic [SW-1:0]  s1_hash;
  logic           s1_last;
  logic           s1_first;
  logic [IW-1:0]  s1_index;

  logic [SW-1:0]  acc;
  logic [SW-1:0]  acc_next;

  // The first element of a document supplies its index directly.
  assign s0_first = (state == IDLE);
  assign s0_index = s0_first ? doc_index : idx_cap;

  // S0 framing FSM; bubbles hold every register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx_cap <= '0;
      busy    <= 1'b0;
    end else if (elem_valid) begin
      unique case (state)
        IDLE: begin
          idx_cap <= doc_index;
          if (!elem_last) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (elem_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  minhash_hash_stage #(
    .SW   (SW),
    .EW   (ELEMENT_WIDTH),
    .IW   (IW),
    .MULT (HASH_MULT),
    .XMSK (HASH_XOR)
  ) u_hash (
    .clk        (clk),
    .rst        (rst),
    .elem_valid (elem_valid),
    .elem_data  (elem_data),
    .elem_last  (elem_last),
    .elem_first (s0_first),
    .elem_index (s0_index),
    .s1_valid   (s1_valid),
    .s1_hash    (s1_hash),
    .s1_last    (s1_last),
    .s1_first   (s1_first),
    .s1_index   (s1_index)
  );

  // Unsigned min; ties keep the current value.
  assign acc_next = s1_first         ? s1_hash :
                    (s1_hash < acc)  ? s1_hash : acc;

  // S2 accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '1;
      valid_out     <= 1'b0;
      signature_out <= '0;
      index_out     <= '0;
    end else begin
      valid_out <= s1_valid & s1_last;
      if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          signature_out <= acc_next;
          index_out     <= s1_index;
        end
      end
    end
  end

`ifdef MINHASH_ELEM_COUNT_EN
  logic [ELEM_COUNT_WIDTH-1:0] cnt;
  logic [ELEM_COUNT_WIDTH-1:0] cnt_next;

  assign cnt_next = s1_first   ? ELEM_COUNT_WIDTH'(1) :
                    (&cnt)     ? cnt : cnt + 1'b1;

  // Saturating element counter, published with the signature.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      elem_count_out <= '0;
    end else if (s1_valid) begin
      cnt <= cnt_next;
      if (s1_last) begin
        elem_count_out <= cnt_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_minhash_signature_gen.sv
// Directed table-driven bench for minhash_signature_gen.
// Define MINHASH_ELEM_COUNT_EN to also check elem_count_out.
module tb_minhash_signature_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        elem_valid;
  logic [31:0] elem_data;
  logic        elem_last;
  logic [9:0]  doc_index;
  logic        valid_out;
  logic [31:0] signature_out;
  logic [9:0]  index_out;
  logic        busy;
`ifdef MINHASH_ELEM_COUNT_EN
  logic [15:0] elem_count_out;
`endif

  minhash_signature_gen dut (
    .clk           (clk),
    .rst           (rst),
    .elem_valid    (elem_valid),
    .elem_data     (elem_data),
    .elem_last     (elem_last),
    .doc_index     (doc_index),
    .valid_out     (valid_out),
    .signature_out (signature_out),
    .index_out     (index_out),
    .busy          (busy)
`ifdef MINHASH_ELEM_COUNT_EN
    ,
    .elem_count_out(elem_count_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              n;
    logic [3:0][31:0] e;
    logic [3:0][3:0]  bub;
    logic [9:0]      idx;
    logic [9:0]      idx_mid;
    bit              b2b;
    logic [31:0]     exp_sig;
    logic [9:0]      exp_idx;
    logic [15:0]     exp_cnt;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] got_sig[$];
  logic [9:0]  got_idx[$];
  int          got_cyc[$];
  logic [15:0] got_cnt[$];

  logic [31:0] exp_sig[$];
  logic [9:0]  exp_idx[$];
  int          exp_cyc[$];
  logic [15:0] exp_cnt[$];

  int checks = 0;
  int errors = 0;

  // Capture every output pulse away from the active edge.
  always @(negedge clk) begin
    if (valid_out) begin
      got_sig.push_back(signature_out);
      got_idx.push_back(index_out);
      got_cyc.push_back(cyc);
`ifdef MINHASH_ELEM_COUNT_EN
      got_cnt.push_back(elem_count_out);
`else
      got_cnt.push_back(16'd0);
`endif
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_doc(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      for (int b = 0; b < int'(v.bub[i]); b++) begin
        elem_valid = 1'b0;
        elem_last  = 1'b1;
        elem_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
      end
      elem_valid = 1'b1;
      elem_data  = v.e[i];
      elem_last  = (i == v.n - 1);
      doc_index  = (i == 0) ? v.idx : v.idx_mid;
      if (i == v.n - 1) begin
        exp_sig.push_back(v.exp_sig);
        exp_idx.push_back(v.exp_idx);
        exp_cyc.push_back(cyc + 2);
        exp_cnt.push_back(v.exp_cnt);
      end
      @(posedge clk);
      #1;
    end
    elem_valid = 1'b0;
    elem_last  = 1'b0;
  endtask

  task automatic drain_and_compare();
    int n;
    chk("pulse_count", 64'(got_sig.size()), 64'(exp_sig.size()));
    n = (got_sig.size() < exp_sig.size()) ? got_sig.size() : exp_sig.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("sig[%0d]", i), 64'(got_sig[i]), 64'(exp_sig[i]));
      chk($sformatf("idx[%0d]", i), 64'(got_idx[i]), 64'(exp_idx[i]));
      chk($sformatf("lat[%0d]", i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
`ifdef MINHASH_ELEM_COUNT_EN
      chk($sformatf("cnt[%0d]", i), 64'(got_cnt[i]), 64'(exp_cnt[i]));
`endif
    end
    got_sig.delete(); got_idx.delete(); got_cyc.delete(); got_cnt.delete();
    exp_sig.delete(); exp_idx.delete(); exp_cyc.delete(); exp_cnt.delete();
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3, input logic [9:0] idx,
                              input logic [9:0] idx_mid, input bit b2b,
                              input logic [31:0] s, input logic [9:0] ei,
                              input logic [15:0] c);
    vec_t v;
    v.n       = n;
    v.e[0]    = e0;
    v.e[1]    = e1;
    v.e[2]    = e2;
    v.e[3]    = e3;
    v.bub     = '0;
    v.idx     = idx;
    v.idx_mid = idx_mid;
    v.b2b     = b2b;
    v.exp_sig = s;
    v.exp_idx = ei;
    v.exp_cnt = c;
    return v;
  endfunction

  vec_t rv;

  initial begin
    // Hash values: h(1)=9E3779B1, h(2)=3C6EF362, h(0)=0,
    // h(3)=DAA66D13, h(FFFFFFFF)=61C8864F, h(80000000)=80000000.
    vecs[0] = mk(1, 32'd1, 0, 0, 0, 10'd5, 10'd5, 0,
                 32'h9E3779B1, 10'd5, 16'd1);
    vecs[1] = mk(3, 32'd1, 32'd2, 32'd0, 0, 10'h201, 10'h201, 0,
                 32'h0, 10'h201, 16'd3);
    vecs[2] = mk(2, 32'd1, 32'd2, 0, 0, 10'd3, 10'd3, 1,
                 32'h3C6EF362, 10'd3, 16'd2);
    vecs[3] = mk(1, 32'd0, 0, 0, 0, 10'd4, 10'd4, 0,
                 32'h0, 10'd4, 16'd1);
    vecs[4] = mk(2, 32'd2, 32'd1, 0, 0, 10'd9, 10'd7, 0,
                 32'h3C6EF362, 10'd9, 16'd2);
    vecs[4].bub[1] = 4'd2;
    vecs[5] = mk(1, 32'hFFFFFFFF, 0, 0, 0, 10'h3FF, 10'h3FF, 0,
                 32'h61C8864F, 10'h3FF, 16'd1);
    vecs[6] = mk(2, 32'h80000000, 32'd2, 0, 0, 10'd1, 10'd1, 0,
                 32'h3C6EF362, 10'd1, 16'd2);
    vecs[7] = mk(4, 32'd3, 32'd3, 32'd3, 32'd3, 10'd12, 10'd12, 0,
                 32'hDAA66D13, 10'd12, 16'd4);

    rst        = 1'b1;
    elem_valid = 1'b0;
    elem_last  = 1'b0;
    elem_data  = '0;
    doc_index  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_sig", 64'(signature_out), 64'd0);
    chk("rst_idx", 64'(index_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
`ifdef MINHASH_ELEM_COUNT_EN
    chk("rst_cnt", 64'(elem_count_out), 64'd0);
`endif
    rst = 1'b0;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      drive_doc(vecs[i]);
      if (!vecs[i].b2b) idle(3);
    end
    idle(4);
    drain_and_compare();
    chk("hold_sig", 64'(signature_out), 64'(vecs[7].exp_sig));
    chk("hold_idx", 64'(index_out), 64'(vecs[7].exp_idx));

    // Reset in the middle of a document.
    elem_valid = 1'b1;
    elem_last  = 1'b0;
    doc_index  = 10'd8;
    elem_data  = 32'd0;
    @(posedge clk);
    #1;
    elem_data = 32'd0;
    @(posedge clk);
    #1;
    chk("busy_mid", 64'(busy), 64'd1);
    elem_valid = 1'b0;
    rst        = 1'b1;
    #1;
    chk("busy_rst", 64'(busy), 64'd0);
    chk("sig_rst", 64'(signature_out), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    chk("no_pulse", 64'(got_sig.size()), 64'd0);

    rv = mk(1, 32'd1, 0, 0, 0, 10'd6, 10'd6, 0, 32'h9E3779B1, 10'd6, 16'd1);
    drive_doc(rv);
    idle(4);
    drain_and_compare();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
